pipe_flow_ctrl: RTL and testbench

//  Pipeline flow controller for the 5-stage RV32 core. Consumes the EX-stage branch decision (pcsrc), jump,

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/load_use_detect.sv | 31 +++
 rtl/pipe_flow_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pipe_flow_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and constants for the RV32 pipeline flow controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FREEZE  = 2'd1,
        ST_REFETCH = 2'd2
    } pipe_state_e;

    // Bubble pattern loaded by pipeline registers on flush (addi x0,x0,0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic int timer_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
//  Module      : load_use_detect
//  Description : Combinational load-use hazard detector (shared with forwarding).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    output logic              loaduse_o
);

    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_hit_rs1 = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    assign w_hit_rs2 = id_use_rs2_i && (id_rs2_i == ex_rd_i);

    // x0 is never a real destination, so a load to x0 never stalls
    assign loaduse_o = ex_memread_i && (ex_rd_i != '0) && (w_hit_rs1 || w_hit_rs2);

endmodule

`default_nettype wire

// File: rtl/pipe_flow_ctrl.sv
// ============================================================================
//  Module      : pipe_flow_ctrl
//  Description : Redirect/stall sequencing for the 5-stage RV32 pipeline.
//                Optional perf counters enabled by macro PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_flow_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int IMEM_TIMEOUT = 15,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pcsrc_ex,
    input  logic              jump_ex,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              imem_ready,
    input  logic              dmem_busy,
    output logic              pc_we,
    output logic              pc_sel,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_we,
    output logic              idex_flush,
    output logic              exmem_we,
    output logic              fetch_err,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int                TMR_W    = timer_width(IMEM_TIMEOUT);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(IMEM_TIMEOUT - 1);

    pipe_state_e      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             fetch_err_q, fetch_err_d;
    logic             w_redirect;
    logic             w_loaduse;
    logic             w_run_eval;

    assign w_redirect = pcsrc_ex || jump_ex;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .ex_memread_i (ex_memread),
        .ex_rd_i      (ex_rd),
        .id_rs1_i     (id_rs1),
        .id_rs2_i     (id_rs2),
        .id_use_rs1_i (id_use_rs1),
        .id_use_rs2_i (id_use_rs2),
        .loaduse_o    (w_loaduse)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            timer_q     <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    always_comb begin
        pc_we       = 1'b1;
        pc_sel      = 1'b0;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_we     = 1'b1;
        idex_flush  = 1'b0;
        exmem_we    = 1'b1;
        state_d     = state_q;
        timer_d     = timer_q;
        fetch_err_d = fetch_err_q;
        w_run_eval  = 1'b0;

        if (!rst_n) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_we    = 1'b0;
            exmem_we   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            case (state_q)
                ST_RUN:    w_run_eval = 1'b1;
                // FREEZE exits in the same cycle dmem_busy drops
                ST_FREEZE: w_run_eval = 1'b1;
                ST_REFETCH: begin
                    if (dmem_busy) begin
                        pc_we    = 1'b0;
                        ifid_we  = 1'b0;
                        idex_we  = 1'b0;
                        exmem_we = 1'b0;
                    end else if (imem_ready) begin
                        state_d = ST_RUN;
                    end else begin
                        pc_we      = 1'b0;
                        ifid_flush = 1'b1;
                        timer_d    = timer_q + TMR_W'(1);
                        if (timer_q == TMR_LAST) begin
                            fetch_err_d = 1'b1;
                            state_d     = ST_RUN;
                        end
                    end
                end
                default: state_d = ST_RUN;
            endcase

            if (w_run_eval) begin
                state_d = ST_RUN;
                if (dmem_busy) begin
                    // redirect stays parked in EX while the memory stage is frozen
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    idex_we  = 1'b0;
                    exmem_we = 1'b0;
                    state_d  = ST_FREEZE;
                end else if (w_redirect) begin
                    pc_sel     = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    timer_d    = '0;
                    state_d    = ST_REFETCH;
                end else if (w_loaduse) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                end else if (!imem_ready) begin
                    pc_we      = 1'b0;
                    ifid_flush = 1'b1;
                end
            end
        end
    end

    assign fetch_err = fetch_err_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // pc_sel is asserted exactly on cycles a redirect is taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pc_sel) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if (!pc_we) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign flush_cnt = flush_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign flush_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_flow_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_flow_ctrl
//  Description : Self-checking bench for pipe_flow_ctrl against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_flow_ctrl;

    localparam int C_TIMEOUT = 15;
    localparam int C_CNT_W   = 32;

    logic        clk = 1'b0;
    logic        rst_n, pcsrc_ex, jump_ex, ex_memread;
    logic [4:0]  ex_rd, id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2, imem_ready, dmem_busy;
    logic        pc_we, pc_sel, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, fetch_err;
    logic [C_CNT_W-1:0] flush_cnt, stall_cnt;

    int checks   = 0;
    int failures = 0;

    // Model: only "waiting for refetch" matters; a frozen pipe behaves like normal run
    bit                 m_refetch;
    int                 m_waited;
    bit                 m_err;
    logic [C_CNT_W-1:0] m_flush;
    logic [C_CNT_W-1:0] m_stall;

    pipe_flow_ctrl #(
        .REG_AW       (5),
        .IMEM_TIMEOUT (C_TIMEOUT),
        .CNT_W        (C_CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pcsrc_ex   (pcsrc_ex),
        .jump_ex    (jump_ex),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .imem_ready (imem_ready),
        .dmem_busy  (dmem_busy),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .ifid_we    (ifid_we),
        .ifid_flush (ifid_flush),
        .idex_we    (idex_we),
        .idex_flush (idex_flush),
        .exmem_we   (exmem_we),
        .fetch_err  (fetch_err),
        .flush_cnt  (flush_cnt),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {pc_we,pc_sel,ifid_we,ifid_flush,idex_we,idex_flush,exmem_we}
    function automatic logic [6:0] model_out();
        bit lu;
        lu = ex_memread && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (!rst_n)                   return 7'b0001010;
        if (dmem_busy)                return 7'b0000000;
        if (m_refetch)                return imem_ready ? 7'b1010101 : 7'b0011101;
        if (pcsrc_ex || jump_ex)      return 7'b1111111;
        if (lu)                       return 7'b0000111;
        if (!imem_ready)              return 7'b0011101;
        return 7'b1010101;
    endfunction

    task automatic set_in(input bit rst, input bit pc, input bit jp, input bit mr,
                          input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                          input bit u1, input bit u2, input bit rdy, input bit busy);
        rst_n = rst; pcsrc_ex = pc; jump_ex = jp; ex_memread = mr;
        ex_rd = rd; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
        imem_ready = rdy; dmem_busy = busy;
    endtask

    task automatic run_cycle(input string tag);
        logic [6:0] exp_o;
        @(negedge clk);
        exp_o = model_out();
        check({tag, ".ctrl"}, 64'({pc_we, pc_sel, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we}),
              64'(exp_o));
        check({tag, ".fetch_err"}, 64'(fetch_err), 64'(m_err));
`ifdef PERF_CNT_EN
        check({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
        check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
`else
        check({tag, ".flush_cnt"}, 64'(flush_cnt), 64'd0);
        check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'd0);
`endif
        if (!rst_n) begin
            m_refetch = 0; m_waited = 0; m_err = 0; m_flush = '0; m_stall = '0;
        end else begin
            if (!exp_o[6]) m_stall = m_stall + 1;
            if (!dmem_busy) begin
                if (m_refetch) begin
                    if (imem_ready) m_refetch = 0;
                    else begin
                        m_waited++;
                        if (m_waited == C_TIMEOUT) begin
                            m_err = 1;
                            m_refetch = 0;
                        end
                    end
                end else if (pcsrc_ex || jump_ex) begin
                    m_refetch = 1; m_waited = 0; m_flush = m_flush + 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
            run_cycle("idle");
        end
    endtask

    initial begin
        m_refetch = 0; m_waited = 0; m_err = 0; m_flush = '0; m_stall = '0;

        // Reset state
        set_in(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        run_cycle("reset");
        run_cycle("reset");
        idle(2);

        // 1: branch redirect with fetch ready
        set_in(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        run_cycle("t1_redirect");
        check("t1_pc_sel", 64'(pc_sel), 64'd0);
        set_in(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        run_cycle("t1_exit");
        idle(1);

        // 2: load-use on rs2 costs one bubble
        set_in(1, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 1, 1, 0);
        run_cycle("t2_loaduse");
        idle(1);

        // 3: load to x0 never stalls
        set_in(1, 0, 0, 1, 5'd0, 5'd0, 5'd3, 1, 0, 1, 0);
        run_cycle("t3_x0");

        // 4: memory freeze holds a pending branch for 3 cycles
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
            run_cycle("t4_freeze");
        end
        set_in(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        run_cycle("t4_redirect");
        idle(2);

        // 5: imem timeout after redirect
        set_in(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        run_cycle("t5_jump");
        for (int i = 0; i < C_TIMEOUT + 3; i++) begin
            set_in(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
            run_cycle("t5_wait");
        end
        check("t5_sticky_err", 64'(fetch_err), 64'd1);
        idle(3);
        check("t5_err_held", 64'(fetch_err), 64'd1);

        // 6: redirect beats load-use, then reset mid-refetch
        set_in(1, 1, 0, 1, 5'd7, 5'd7, 5'd0, 1, 0, 1, 0);
        run_cycle("t6_both");
        set_in(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        run_cycle("t6_wait");
        set_in(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        run_cycle("t6_reset");
        check("t6_err_cleared", 64'(fetch_err), 64'd0);
        set_in(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        run_cycle("t6_after");

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(0, 79) != 0),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0),
                   ($urandom_range(0, 2) == 0),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
            run_cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
